// File: rtl/uart_tx_arb.sv
// Four-requester round-robin arbiter feeding a single UART transmitter.
// States: IDLE arbitrate/accept | LAUNCH start_tx pulse | WAIT await tx_done or timeout | GAP idle spacing.
module uart_tx_arb #(
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned TIMEOUT    = 200000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        uart_en,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic        start_tx,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic        timeout_err,
  output logic [15:0] tx_count
);

  localparam logic [17:0] GAP_LOAD = (GAP_CYCLES == 0) ? 18'd0 : 18'(GAP_CYCLES - 1);
  localparam logic [17:0] TO_LAST  = (TIMEOUT == 0) ? 18'd0 : 18'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP} state_t;

  state_t      r_state;
  logic [1:0]  r_last_grant;
  logic [1:0]  r_grant_id;
  logic [7:0]  r_tx_data;
  logic [15:0] r_tx_count;
  logic [17:0] r_cnt;
  logic        r_start_tx;
  logic        r_busy;

  logic [1:0]  w_win;
  logic [1:0]  w_idx;
  logic        w_win_vld;
  logic        w_accept;
  logic        w_timeout_hit;
  logic [7:0]  w_win_data;

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    w_win     = r_last_grant;
    w_idx     = r_last_grant;
    w_win_vld = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last_grant + 2'(k);
      if (!w_win_vld && req_valid[w_idx]) begin
        w_win     = w_idx;
        w_win_vld = 1'b1;
      end
    end
  end

  assign w_win_data    = req_data[{w_win, 3'b000} +: 8];
  assign w_accept      = !reset && (r_state == S_IDLE) && uart_en && w_win_vld;
  assign w_timeout_hit = (r_state == S_WAIT) && (r_cnt == TO_LAST);

  assign req_ready   = w_accept ? (4'b0001 << w_win) : 4'b0000;
  assign timeout_err = !reset && w_timeout_hit && !tx_done;
  assign start_tx    = r_start_tx;
  assign busy        = r_busy;
  assign tx_data     = r_tx_data;
  assign grant_id    = r_grant_id;
  assign tx_count    = r_tx_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 2'd3;
      r_grant_id   <= 2'd0;
      r_tx_data    <= 8'h00;
      r_tx_count   <= 16'd0;
      r_cnt        <= 18'd0;
      r_start_tx   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_tx_data    <= w_win_data;
            r_grant_id   <= w_win;
            r_last_grant <= w_win;
            r_start_tx   <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_start_tx <= 1'b0;
          r_cnt      <= 18'd0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          // tx_done takes priority over a coincident timeout.
          if (tx_done) begin
            r_tx_count <= r_tx_count + 16'd1;
            r_cnt      <= GAP_LOAD;
            r_state    <= S_GAP;
          end else if (w_timeout_hit) begin
            r_cnt   <= GAP_LOAD;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 18'd1;
          end
        end
        S_GAP: begin
          if (r_cnt == 18'd0) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 18'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: grants are predicted by a round-robin model at accept
// time and compared against the launched frame.
module tb_uart_tx_arb;

  localparam int GAP = 16;
  localparam int TO  = 100;

  logic        clock = 1'b0;
  logic        reset;
  logic        uart_en;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        start_tx;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;
  logic [15:0] tx_count;

  uart_tx_arb #(.GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .uart_en(uart_en),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .start_tx(start_tx), .tx_data(tx_data), .tx_done(tx_done),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err),
    .tx_count(tx_count)
  );

  always #5 clock = ~clock;

  typedef struct { logic [1:0] id; logic [7:0] data; } exp_t;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [1:0]  m_last;
  logic [15:0] m_count;

  task automatic model_reset();
    m_last  = 2'd3;
    m_count = 16'd0;
    sb.delete();
  endtask

  // One complete frame. done_after: WAIT cycle carrying tx_done (1..TO), or <0 for none.
  task automatic do_frame(input logic [3:0] vld, input logic [31:0] dat, input int done_after,
                          input bit hold, input bit immediate, input string tag);
    int    n;
    int    w;
    int    wait_len;
    exp_t  e;
    logic  exp_to;
    req_data  = dat;
    req_valid = vld;
    uart_en   = 1'b1;
    #1;
    n = 0;
    while (req_ready == 4'b0000 && n < 50) begin
      @(negedge clock); #1;
      n++;
    end
    checks++;
    if (req_ready === 4'b0000) begin
      errors++;
      $display("FAIL %s accept_timeout: req_ready=%b required nonzero within 50 cycles", tag, req_ready);
      return;
    end
    if (immediate) begin
      checks++;
      if (n !== 0) begin
        errors++;
        $display("FAIL %s accept_latency: waited %0d extra cycles, required 0", tag, n);
      end
    end
    w = -1;
    for (int k = 1; k <= 4; k++) begin
      if (w < 0 && vld[(int'(m_last) + k) % 4]) w = (int'(m_last) + k) % 4;
    end
    checks++;
    if (req_ready !== (4'b0001 << w)) begin
      errors++;
      $display("FAIL %s req_ready: got %b required %b", tag, req_ready, 4'b0001 << w);
    end
    sb.push_back('{id: 2'(w), data: dat[8*w +: 8]});
    m_last = 2'(w);

    @(negedge clock); #1;
    if (!hold) begin
      req_valid = 4'b0000;
      req_data  = ~dat;
    end
    e = sb.pop_front();
    checks++;
    if ({start_tx, busy, req_ready, grant_id, tx_data} !== {1'b1, 1'b1, 4'b0000, e.id, e.data}) begin
      errors++;
      $display("FAIL %s launch: start_tx=%b busy=%b ready=%b grant=%0d data=%h required 1 1 0000 %0d %h",
               tag, start_tx, busy, req_ready, grant_id, tx_data, e.id, e.data);
    end

    wait_len = (done_after < 0) ? TO : done_after;
    for (int j = 1; j <= wait_len; j++) begin
      @(negedge clock);
      if (j == done_after) tx_done = 1'b1;
      if (j == 2) uart_en = 1'b0;
      #1;
      exp_to = (done_after < 0) && (j == TO);
      checks++;
      if ({start_tx, timeout_err, busy, req_ready, tx_data} !== {1'b0, exp_to, 1'b1, 4'b0000, e.data}) begin
        errors++;
        $display("FAIL %s wait[%0d]: start_tx=%b timeout_err=%b busy=%b ready=%b data=%h required 0 %b 1 0000 %h",
                 tag, j, start_tx, timeout_err, busy, req_ready, tx_data, exp_to, e.data);
      end
    end

    @(negedge clock);
    tx_done = 1'b0;
    #1;
    if (done_after >= 0) m_count = m_count + 16'd1;
    checks++;
    if ({tx_count, timeout_err} !== {m_count, 1'b0}) begin
      errors++;
      $display("FAIL %s count_after_frame: tx_count=%0d timeout_err=%b required %0d 0",
               tag, tx_count, timeout_err, m_count);
    end

    for (int g = 1; g <= GAP; g++) begin
      tx_done = (g == 3);
      checks++;
      if ({busy, req_ready, start_tx} !== {1'b1, 4'b0000, 1'b0}) begin
        errors++;
        $display("FAIL %s gap[%0d]: busy=%b ready=%b start_tx=%b required 1 0000 0",
                 tag, g, busy, req_ready, start_tx);
      end
      @(negedge clock); #1;
    end
    tx_done = 1'b0;
    checks++;
    if ({busy, tx_count} !== {1'b0, m_count}) begin
      errors++;
      $display("FAIL %s gap_end: busy=%b tx_count=%0d required 0 %0d", tag, busy, tx_count, m_count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; uart_en = 1'b1; req_valid = 4'b1111; req_data = 32'hDEADBEEF; tx_done = 1'b0;
    @(negedge clock); @(negedge clock); #1;
    checks++;
    if ({req_ready, start_tx, busy, timeout_err, tx_count, grant_id, tx_data} !==
        {4'b0000, 1'b0, 1'b0, 1'b0, 16'd0, 2'd0, 8'h00}) begin
      errors++;
      $display("FAIL reset_state: ready=%b start=%b busy=%b to=%b cnt=%0d grant=%0d data=%h required all zero",
               req_ready, start_tx, busy, timeout_err, tx_count, grant_id, tx_data);
    end
    req_valid = 4'b0000;
    reset = 1'b0;
    model_reset();
    @(negedge clock); #1;
  endtask

  task automatic test_single();
    do_frame(4'b0100, 32'h00A5_0000, 5, 1'b0, 1'b0, "single");
    checks++;
    if ({grant_id, tx_count} !== {2'd2, 16'd1}) begin
      errors++;
      $display("FAIL single_result: grant_id=%0d tx_count=%0d required 2 1", grant_id, tx_count);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] order [5];
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    reset = 1'b1;
    @(negedge clock); #1;
    reset = 1'b0;
    model_reset();
    for (int f = 0; f < 5; f++) begin
      do_frame(4'b1111, 32'h4433_2211, 3 + f, 1'b1, (f != 0), "fair");
      checks++;
      if (grant_id !== order[f]) begin
        errors++;
        $display("FAIL fair_order[%0d]: grant_id=%0d required %0d", f, grant_id, order[f]);
      end
    end
    req_valid = 4'b0000;
    @(negedge clock); #1;
  endtask

  task automatic test_timeout();
    do_frame(4'b0010, 32'h0000_5A00, -1, 1'b0, 1'b0, "timeout");
    do_frame(4'b1000, 32'hC300_0000, TO, 1'b0, 1'b0, "done_vs_timeout");
  endtask

  task automatic test_reset_mid();
    uart_en = 1'b1; req_valid = 4'b0010; req_data = 32'h0000_7700;
    #1;
    for (int n = 0; n < 50 && req_ready == 4'b0000; n++) begin
      @(negedge clock); #1;
    end
    req_valid = 4'b0000;
    repeat (4) @(negedge clock);
    reset = 1'b1; req_valid = 4'b1001; req_data = 32'h6600_0011;
    #1;
    checks++;
    if ({req_ready, timeout_err} !== {4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_during: ready=%b timeout_err=%b required 0000 0", req_ready, timeout_err);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({busy, start_tx, tx_count, req_ready} !== {1'b0, 1'b0, 16'd0, 4'b0001}) begin
      errors++;
      $display("FAIL reset_mid_after: busy=%b start=%b cnt=%0d ready=%b required 0 0 0 0001",
               busy, start_tx, tx_count, req_ready);
    end
    do_frame(4'b1001, 32'h6600_0011, 2, 1'b0, 1'b1, "post_reset");
  endtask

  task automatic test_gate_wrap();
    uart_en = 1'b0; req_valid = 4'b0001; req_data = 32'h0000_0042;
    for (int c = 0; c < 5; c++) begin
      tx_done = (c == 2);
      @(negedge clock); #1;
      checks++;
      if ({req_ready, busy, tx_count} !== {4'b0000, 1'b0, m_count}) begin
        errors++;
        $display("FAIL gate[%0d]: ready=%b busy=%b cnt=%0d required 0000 0 %0d",
                 c, req_ready, busy, tx_count, m_count);
      end
    end
    tx_done = 1'b0;
    req_valid = 4'b0000;
    force dut.r_tx_count = 16'hFFFF;
    @(negedge clock);
    release dut.r_tx_count;
    @(negedge clock); #1;
    m_count = 16'hFFFF;
    do_frame(4'b0001, 32'h0000_0042, 1, 1'b0, 1'b0, "wrap");
    checks++;
    if (tx_count !== 16'd0) begin
      errors++;
      $display("FAIL wrap_result: tx_count=%0d required 0", tx_count);
    end
  endtask

  initial begin
    reset = 1'b1; uart_en = 1'b0; req_valid = 4'b0000; req_data = 32'h0; tx_done = 1'b0;
    model_reset();
    @(negedge clock); #1;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_reset_mid();
    test_gate_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
